// File: rtl/alarm_frame_responder_if.sv
// UART reader/writer link for the alarm frame responder.
// The reader strobes bytes in; the writer takes reply bytes on ready/send.
interface alarm_frame_responder_if;
    logic       arrived;
    logic [7:0] dataR;
    logic       ready;
    logic       send;
    logic [7:0] data;

    modport master (
        output arrived,
        output dataR,
        output ready,
        input  send,
        input  data
    );

    modport slave (
        input  arrived,
        input  dataR,
        input  ready,
        output send,
        output data
    );
endinterface

// File: rtl/alarm_frame_responder.sv
// Parses SYNC/ID/CODE/CHK alarm frames from the UART reader,
// reports accepted alarms and answers addressed frames with ACK/NAK.
module alarm_frame_responder #(
    parameter logic [7:0] NODE_ID = 8'h01,
    parameter int         TIMEOUT = 100000
) (
    input  logic                    Clock,
    input  logic                    Reset,
    alarm_frame_responder_if.slave  link,
    output logic                    alarm_valid,
    output logic [7:0]              alarm_code,
    output logic [7:0]              alarm_src,
    output logic                    frame_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 2);

    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef enum logic [1:0] {
        S_SYNC,
        S_ID,
        S_CODE,
        S_CHK
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    id_q;
    logic [7:0]    code_q;
    logic [7:0]    sum;
    logic [CW-1:0] cnt;
    logic          tmo;
    logic          chk_done;
    logic          addressed;
    logic          chk_ok;
    logic          rep_q;
    logic [7:0]    rep_byte;
    logic          pend;
    logic [7:0]    data_q;

    assign sum       = id_q + code_q;
    assign chk_done  = link.arrived && (state == S_CHK);
    assign addressed = (id_q == NODE_ID) || (id_q == 8'hFF);
    assign chk_ok    = (link.dataR == sum);

    // A byte arriving in the timeout cycle wins over the timeout.
    always_comb begin
        state_nx = state;
        tmo      = 1'b0;
        if (link.arrived) begin
            unique case (state)
                S_SYNC: if (link.dataR == SYNC) state_nx = S_ID;
                S_ID:   state_nx = S_CODE;
                S_CODE: state_nx = S_CHK;
                S_CHK:  state_nx = S_SYNC;
                default: state_nx = S_SYNC;
            endcase
        end else if (state != S_SYNC && cnt == TLAST) begin
            tmo      = 1'b1;
            state_nx = S_SYNC;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_SYNC;
            cnt   <= '0;
            id_q  <= '0;
            code_q <= '0;
        end else begin
            state <= state_nx;
            if (link.arrived || state == S_SYNC)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (link.arrived && state == S_ID)
                id_q <= link.dataR;
            if (link.arrived && state == S_CODE)
                code_q <= link.dataR;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            alarm_valid <= 1'b0;
            frame_err   <= 1'b0;
            alarm_code  <= '0;
            alarm_src   <= '0;
        end else begin
            alarm_valid <= chk_done && addressed && chk_ok;
            frame_err   <= tmo || (chk_done && addressed && !chk_ok);
            if (chk_done && addressed && chk_ok) begin
                alarm_code <= code_q;
                alarm_src  <= id_q;
            end
        end
    end

    // Reply is staged one cycle, then held in the single pending slot.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rep_q    <= 1'b0;
            rep_byte <= '0;
            pend     <= 1'b0;
            data_q   <= '0;
        end else begin
            rep_q <= chk_done && addressed;
            if (chk_done && addressed)
                rep_byte <= chk_ok ? ACK : NAK;
            if (rep_q) begin
                pend   <= 1'b1;
                data_q <= rep_byte;
            end else if (pend && link.ready) begin
                pend <= 1'b0;
            end
        end
    end

    assign link.send = pend && link.ready;
    assign link.data = data_q;

endmodule

// File: tb/tb_alarm_frame_responder.sv
// Directed bench for alarm_frame_responder: frame vector table
// plus timeout, back-pressure and mid-frame reset sequences.
module tb_alarm_frame_responder;

    logic       Clock;
    logic       Reset;
    logic       alarm_valid;
    logic [7:0] alarm_code;
    logic [7:0] alarm_src;
    logic       frame_err;

    int passed;
    int total;
    int sends;
    int s0;
    logic early;

    alarm_frame_responder_if lnk ();

    alarm_frame_responder #(
        .NODE_ID (8'h01),
        .TIMEOUT (20)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .link        (lnk),
        .alarm_valid (alarm_valid),
        .alarm_code  (alarm_code),
        .alarm_src   (alarm_src),
        .frame_err   (frame_err)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock)
        if (lnk.send) sends++;

    typedef struct {
        logic [31:0] bytes;
        logic        v;
        logic        e;
        logic        s;
        logic [7:0]  d;
        logic [7:0]  code;
        logic [7:0]  src;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic put_byte(input logic [7:0] b);
        lnk.arrived = 1'b1;
        lnk.dataR   = b;
        @(posedge Clock);
        #1;
        lnk.arrived = 1'b0;
    endtask

    task automatic put_frame(input logic [31:0] f);
        for (int j = 0; j < 4; j++)
            put_byte(f[31-8*j -: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        sends  = 0;
        Clock  = 1'b0;
        Reset  = 1'b0;
        lnk.arrived = 1'b0;
        lnk.dataR   = 8'h00;
        lnk.ready   = 1'b1;

        vecs[0] = '{32'hA5013334, 1, 0, 1, 8'h06, 8'h33, 8'h01};
        vecs[1] = '{32'hA5017700, 0, 1, 1, 8'h15, 8'h33, 8'h01};
        vecs[2] = '{32'hA5023335, 0, 0, 0, 8'h00, 8'h33, 8'h01};
        vecs[3] = '{32'hA5FF100F, 1, 0, 1, 8'h06, 8'h10, 8'hFF};
        vecs[4] = '{32'hA501A5A6, 1, 0, 1, 8'h06, 8'hA5, 8'h01};
        vecs[5] = '{32'hA5FF00FF, 1, 0, 1, 8'h06, 8'h00, 8'hFF};
        vecs[6] = '{32'hA501FF00, 1, 0, 1, 8'h06, 8'hFF, 8'h01};
        vecs[7] = '{32'hA5021000, 0, 0, 0, 8'h00, 8'hFF, 8'h01};
        vecs[8] = '{32'hA5FF2000, 0, 1, 1, 8'h15, 8'hFF, 8'h01};

        idle(3);
        chk("rst_valid", 32'(alarm_valid), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_code", 32'(alarm_code), 0);
        chk("rst_src", 32'(alarm_src), 0);
        chk("rst_send", 32'(lnk.send), 0);
        chk("rst_data", 32'(lnk.data), 0);
        Reset = 1'b1;
        idle(1);

        for (int i = 0; i < 9; i++) begin
            s0 = sends;
            put_frame(vecs[i].bytes);
            chk($sformatf("v%0d_valid", i), 32'(alarm_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d_err", i), 32'(frame_err), 32'(vecs[i].e));
            chk($sformatf("v%0d_code", i), 32'(alarm_code), 32'(vecs[i].code));
            chk($sformatf("v%0d_src", i), 32'(alarm_src), 32'(vecs[i].src));
            chk($sformatf("v%0d_send_n1", i), 32'(lnk.send), 0);
            idle(1);
            chk($sformatf("v%0d_send_n2", i), 32'(lnk.send), 32'(vecs[i].s));
            if (vecs[i].s)
                chk($sformatf("v%0d_data", i), 32'(lnk.data), 32'(vecs[i].d));
            idle(3);
            chk($sformatf("v%0d_nsend", i), 32'(sends - s0), 32'(vecs[i].s));
        end

        // timeout: last byte in cycle M, frame_err expected in M+20
        put_byte(8'hA5);
        put_byte(8'h01);
        early = 1'b0;
        repeat (18) begin
            if (frame_err) early = 1'b1;
            idle(1);
        end
        chk("tmo_early", 32'(early | frame_err), 0);
        idle(1);
        chk("tmo_err", 32'(frame_err), 1);
        put_byte(8'h7E);
        put_frame(32'hA5013334);
        chk("tmo_resync_valid", 32'(alarm_valid), 1);
        chk("tmo_resync_code", 32'(alarm_code), 32'h33);
        idle(4);

        // back-pressure: two good frames while writer is busy
        lnk.ready = 1'b0;
        s0 = sends;
        put_frame(32'hA5015556);
        chk("bp_valid1", 32'(alarm_valid), 1);
        put_frame(32'hA5014445);
        chk("bp_valid2", 32'(alarm_valid), 1);
        chk("bp_code2", 32'(alarm_code), 32'h44);
        idle(45);
        chk("bp_nosend", 32'(sends - s0), 0);
        lnk.ready = 1'b1;
        #1;
        chk("bp_send", 32'(lnk.send), 1);
        chk("bp_data", 32'(lnk.data), 32'h06);
        idle(1);
        chk("bp_send_once", 32'(lnk.send), 0);
        idle(3);
        chk("bp_nsend", 32'(sends - s0), 1);

        // reset mid-frame
        put_byte(8'hA5);
        put_byte(8'h01);
        Reset = 1'b0;
        #1;
        chk("mrst_code", 32'(alarm_code), 0);
        chk("mrst_src", 32'(alarm_src), 0);
        chk("mrst_data", 32'(lnk.data), 0);
        chk("mrst_send", 32'(lnk.send), 0);
        chk("mrst_valid", 32'(alarm_valid), 0);
        chk("mrst_err", 32'(frame_err), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        s0 = sends;
        put_byte(8'h33);
        put_byte(8'h34);
        chk("mrst_tail_valid", 32'(alarm_valid), 0);
        chk("mrst_tail_err", 32'(frame_err), 0);
        idle(3);
        chk("mrst_tail_nsend", 32'(sends - s0), 0);
        put_frame(32'hA5013334);
        chk("mrst_full_valid", 32'(alarm_valid), 1);
        chk("mrst_full_src", 32'(alarm_src), 32'h01);
        idle(1);
        chk("mrst_full_send", 32'(lnk.send), 1);
        chk("mrst_full_data", 32'(lnk.data), 32'h06);
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
